// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two WIDTH-bit operands four bits per cycle using an external
//   combinational 4-bit full adder (bit4_full_add). Operands are taken over a
//   valid/ready handshake, fed to the adder one nibble per cycle together with
//   the running carry, and the assembled sum is offered over a second
//   valid/ready handshake.
//
//   Build option: define OVERFLOW_FLAG_EN to add the o_ovf port (two's-
//   complement overflow flag, valid with o_valid).
//
//   Ports:
//     i_clk, i_rst       clock, asynchronous active-high reset
//     i_valid / o_ready  operand handshake (i_a, i_b, i_cin)
//     o_add_a/b/cin      nibble operands and running carry to the adder
//     i_add_sum/carry    combinational result returned by the adder
//     o_valid / i_ready  result handshake (o_sum, o_carry[, o_ovf])
//     o_busy             high while nibbles are being processed
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [3:0]       o_add_a,
  output logic [3:0]       o_add_b,
  output logic             o_add_cin,
  input  logic [3:0]       i_add_sum,
  input  logic             i_add_carry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_busy
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [IDXW-1:0]   idx;
  // Operand shift registers: hold the nibbles not yet presented to the adder.
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  // Sum assembles from the top: each new nibble enters at the MSB end and
  // after NIB shifts nibble 0 sits at the bottom.
  logic [WIDTH-1:0]  sum_reg;

  logic [WIDTH-1:0]  a_nxt;
  logic [WIDTH-1:0]  b_nxt;
  logic [WIDTH-1:0]  sum_nxt;

  // Next values of the shift registers for the current RUN edge
  always_comb begin
    a_nxt   = a_sh >> 4;
    b_nxt   = b_sh >> 4;
    sum_nxt = (sum_reg >> 4) | (WIDTH'(i_add_sum) << (WIDTH - 4));
  end

  // Sequencer: state, nibble feed to the adder and result capture
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      idx       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_reg   <= '0;
      o_ready   <= 1'b1;
      o_add_a   <= '0;
      o_add_b   <= '0;
      o_add_cin <= 1'b0;
      o_valid   <= 1'b0;
      o_sum     <= '0;
      o_carry   <= 1'b0;
      o_busy    <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      o_ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            // Nibble 0 goes straight to the adder; the rest wait in a_sh/b_sh.
            a_sh      <= i_a >> 4;
            b_sh      <= i_b >> 4;
            o_add_a   <= i_a[3:0];
            o_add_b   <= i_b[3:0];
            o_add_cin <= i_cin;
            idx       <= '0;
            sum_reg   <= '0;
            o_ready   <= 1'b0;
            o_busy    <= 1'b1;
            state     <= RUN;
          end
        end

        RUN: begin
          sum_reg <= sum_nxt;
          if (idx == LAST_IDX) begin
            o_sum     <= sum_nxt;
            o_carry   <= i_add_carry;
`ifdef OVERFLOW_FLAG_EN
            // Carry into the MSB xor carry out of the MSB.
            o_ovf     <= (o_add_a[3] ^ o_add_b[3] ^ i_add_sum[3]) ^ i_add_carry;
`endif
            o_add_a   <= '0;
            o_add_b   <= '0;
            o_add_cin <= 1'b0;
            o_busy    <= 1'b0;
            o_valid   <= 1'b1;
            state     <= DONE;
          end else begin
            idx       <= idx + IDXW'(1);
            o_add_a   <= a_sh[3:0];
            o_add_b   <= b_sh[3:0];
            o_add_cin <= i_add_carry;
            a_sh      <= a_nxt;
            b_sh      <= b_nxt;
          end
        end

        DONE: begin
          // No bypass: o_ready rises only after the result handshake edge.
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16). The external 4-bit
// adder is modelled behaviourally; expected results come from a vector table
// and from plain wide arithmetic for random operands.
module tb_nibble_serial_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic [3:0]       o_add_a;
  logic [3:0]       o_add_b;
  logic             o_add_cin;
  logic [3:0]       add_sum;
  logic             add_carry;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;
  logic             o_busy;
`ifdef OVERFLOW_FLAG_EN
  logic             o_ovf;
`endif

  int checks;
  int failures;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_cin       (i_cin),
    .o_add_a     (o_add_a),
    .o_add_b     (o_add_b),
    .o_add_cin   (o_add_cin),
    .i_add_sum   (add_sum),
    .i_add_carry (add_carry),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_sum       (o_sum),
    .o_carry     (o_carry),
    .o_busy      (o_busy)
`ifdef OVERFLOW_FLAG_EN
    ,
    .o_ovf       (o_ovf)
`endif
  );

  // Behavioural bit4_full_add
  assign {add_carry, add_sum} = 5'(o_add_a) + 5'(o_add_b) + 5'(o_add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
    int          hold;   // cycles i_ready is held low in DONE
    logic        spur;   // present a stray request during RUN
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One full transaction with cycle-by-cycle checks of the adder feed.
  task automatic do_op(input vec_t v);
    logic [31:0] mask;
    logic [31:0] cin_exp;
    logic [WIDTH-1:0] held_sum;
    @(negedge clk);
    i_valid = 1'b1;
    i_a     = v.a;
    i_b     = v.b;
    i_cin   = v.cin;
    i_ready = 1'b0;
    check("ready_idle", 32'(o_ready), 32'd1);
    @(posedge clk);
    for (int k = 0; k < NIB; k++) begin
      @(negedge clk);
      if (v.spur) begin
        i_valid = 1'b1;
        i_a     = 16'hAAAA;
        i_b     = 16'h5555;
        i_cin   = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      mask    = (32'd1 << (4 * k)) - 32'd1;
      cin_exp = ((32'(v.a) & mask) + (32'(v.b) & mask) + 32'(v.cin)) >> (4 * k);
      check("run_busy",  32'(o_busy),  32'd1);
      check("run_ready", 32'(o_ready), 32'd0);
      check("run_valid", 32'(o_valid), 32'd0);
      check("run_add_a", 32'(o_add_a), (32'(v.a) >> (4 * k)) & 32'hF);
      check("run_add_b", 32'(o_add_b), (32'(v.b) >> (4 * k)) & 32'hF);
      check("run_add_cin", 32'(o_add_cin), cin_exp);
      @(posedge clk);
    end
    @(negedge clk);
    i_valid = 1'b0;
    check("done_valid", 32'(o_valid), 32'd1);
    check("done_sum",   32'(o_sum),   32'(v.sum));
    check("done_carry", 32'(o_carry), 32'(v.carry));
    check("done_busy",  32'(o_busy),  32'd0);
    check("done_add_a", 32'(o_add_a), 32'd0);
    check("done_add_cin", 32'(o_add_cin), 32'd0);
`ifdef OVERFLOW_FLAG_EN
    check("done_ovf", 32'(o_ovf), 32'(v.ovf));
`endif
    held_sum = o_sum;
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_sum",   32'(o_sum),   32'(held_sum));
    end
    i_ready = 1'b1;
    check("hs_ready_low", 32'(o_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    i_ready = 1'b0;
    check("post_valid", 32'(o_valid), 32'd0);
    check("post_ready", 32'(o_ready), 32'd1);
  endtask

  vec_t tbl[8];
  vec_t rv;
  logic [16:0] full;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    i_valid  = 1'b0;
    i_a      = '0;
    i_b      = '0;
    i_cin    = 1'b0;
    i_ready  = 1'b0;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0};
    tbl[2] = '{16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 0, 1'b1};
    tbl[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 5, 1'b0};
    tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1, 1'b0};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 2, 1'b0};
    tbl[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_busy",  32'(o_busy),  32'd0);
    check("rst_sum",   32'(o_sum),   32'd0);
    check("rst_carry", 32'(o_carry), 32'd0);
    check("rst_add",   32'({o_add_a, o_add_b, o_add_cin}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) do_op(tbl[i]);

    // Reset after the second RUN edge aborts the operation
    @(negedge clk);
    i_valid = 1'b1;
    i_a     = 16'h1234;
    i_b     = 16'h4321;
    i_cin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_ready", 32'(o_ready), 32'd1);
    check("abort_valid", 32'(o_valid), 32'd0);
    check("abort_busy",  32'(o_busy),  32'd0);
    check("abort_sum",   32'(o_sum),   32'd0);
    check("abort_carry", 32'(o_carry), 32'd0);
    check("abort_add",   32'({o_add_a, o_add_b, o_add_cin}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(o_valid), 32'd0);
    end
    rv = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0, 1'b0};
    do_op(rv);

    // Random operands against plain wide arithmetic
    for (int r = 0; r < 40; r++) begin
      rv.a     = 16'($urandom);
      rv.b     = 16'($urandom);
      rv.cin   = 1'($urandom);
      full     = 17'(rv.a) + 17'(rv.b) + 17'(rv.cin);
      rv.sum   = full[15:0];
      rv.carry = full[16];
      rv.ovf   = (rv.a[15] == rv.b[15]) && (full[15] != rv.a[15]);
      rv.hold  = int'($urandom_range(0, 2));
      rv.spur  = 1'($urandom);
      do_op(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
